disp_cb_wr_ctrl: RTL and testbench
==================================

Name: disp_cb_wr_ctrl

Overview:
Character-buffer write sequencer between the display register block and the character buffer RAM.
- Turns register-level strobes (row/col pointer update, data write, auto-increment mode) into RAM write cycles.
- Keeps the write pointer inside the character window: address = cb_addr_orig + row*cw_x_size + col, computed with a sequential shift-add.
- Owns a full-buffer clear engine and arbitrates it against uP writes.

Parameters:
CB_AW, 11, character buffer address width; buffer depth = 2**CB_AW.
CLR_CHAR, 8'h20, code written to every location during a clear.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cw_row  in  8  window row for next string start
cw_col  in  8  window column for next string start
cw_row_col_update  in  1  one-cycle pulse: reload pointer from cw_row/cw_col
cw_x_size  in  8  window width in characters (0 means 256)
cw_y_size  in  8  window height in characters (0 means 256)
cb_addr_orig  in  CB_AW  buffer address of window cell (0,0)
cb_wr_addr_inc  in  1  level: auto-advance pointer after each write
cb_wr_en  in  1  one-cycle pulse: write wr_data at pointer
wr_data  in  8  character code
clr_start  in  1  one-cycle pulse: clear entire buffer
cb_we  out  1  RAM write enable
cb_addr  out  CB_AW  RAM write address
cb_din  out  8  RAM write data
busy  out  1  high in LOAD or CLEAR
clr_done  out  1  sticky; set at end of clear, cleared by clr_start or rst
wr_drop  out  1  one-cycle pulse: a uP write was discarded

Behaviour:
- Reset values: cb_we=0, cb_addr=0, cb_din=0, busy=0, clr_done=0, wr_drop=0. Internal state: row=0, col=0, row_base=cb_addr_orig, pending=0. FSM goes to IDLE.
- FSM states: IDLE, LOAD, CLEAR.
- IDLE:
  - clr_start has priority: go to CLEAR, clear clr_done.
  - Otherwise, cw_row_col_update: latch row=cw_row, col=cw_col, acc=cb_addr_orig, mcnt=0; go to LOAD.
  - Otherwise, cb_wr_en or pending: perform a write (below) and clear pending.
- LOAD: 8 cycles of shift-add, one bit of cw_row per cycle, LSB first.
  - acc += (cw_x_size << mcnt) if row[mcnt]; all arithmetic mod 2**CB_AW.
  - After the 8th cycle: row_base=acc; return to IDLE.
  - Total latency from update pulse to IDLE: 9 cycles.
  - cw_x_size and cb_addr_orig are sampled each cycle and must be stable during LOAD.
- Write: cb_wr_en accepted at cycle N drives cb_we=1, cb_addr=row_base+col, cb_din=wr_data at cycle N+1 (registered, one cycle wide).
- Auto-increment, applied in the same cycle the write is issued, only if cb_wr_addr_inc=1:
  - if col >= xs-1 (xs = cw_x_size, 0 treated as 256): col=0, then row step;
  - else col=col+1.
- Row step:
  - if row >= ys-1: row=0, row_base=cb_addr_orig;
  - else row=row+1, row_base=row_base+xs.
  - Last window cell wraps to (0,0).
- Writes arriving while busy:
  - In LOAD, the first cb_wr_en is held in a 1-deep buffer (data captured, pending=1) and issued on the first IDLE cycle.
  - A second write while pending=1 is discarded with wr_drop=1.
  - In CLEAR, every cb_wr_en is discarded with wr_drop=1.
- cw_row_col_update arriving in LOAD restarts LOAD with the new values; pending is kept.
- cw_row_col_update arriving in CLEAR is stored and processed on return to IDLE.
- cw_row_col_update and cb_wr_en in the same cycle in IDLE: the update wins and the write becomes pending.
- CLEAR:
  - cb_we=1 every cycle, cb_din=CLR_CHAR, cb_addr counts 0 to 2**CB_AW-1, one per cycle.
  - After the last address: clr_done=1, cb_we=0, return to IDLE.
  - A clr_start arriving during CLEAR restarts the count at 0.
  - Clear does not change row/col/row_base.
- rst mid-LOAD or mid-CLEAR aborts immediately: cb_we=0 on the next edge, clr_done=0, pending discarded.

Test Plan:
1. Reset, then cb_wr_en with wr_data=8'h41 (orig=0, row=col=0, inc=0) -> cb_we one cycle later, addr=0, din=8'h41. Pointer unchanged on a second write.
2. orig=11'd96, x_size=32, cw_row=3, cw_col=5, update pulse -> busy high 8 cycles. Next write goes to addr 96+96+5=197.
3. inc=1, x_size=4, y_size=2, orig=0, start (0,0), 9 writes -> addresses 0,1,2,3,4,5,6,7,0 (wrap to origin).
4. Update followed one cycle later by two cb_wr_en pulses during LOAD -> first write issued at the computed address after LOAD; wr_drop pulses once for the second.
5. clr_start with CB_AW=11 -> 2048 consecutive cb_we cycles, din=8'h20, addr 0..2047, then clr_done=1. A cb_wr_en during the clear gives wr_drop=1 and no extra write.
6. rst asserted at clear address 500 -> cb_we=0 next cycle, clr_done=0. A following write with default state goes to addr=cb_addr_orig.

Source files
------------

// File: rtl/disp_cb_wr_ctrl.sv
// Character-buffer write sequencer: turns register strobes into RAM writes,
// tracks the window pointer with a shift-add row base, and runs a full clear.
module disp_cb_wr_ctrl #(
  parameter int          CB_AW    = 11,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cw_row,
  input  logic [7:0]       cw_col,
  input  logic             cw_row_col_update,
  input  logic [7:0]       cw_x_size,
  input  logic [7:0]       cw_y_size,
  input  logic [CB_AW-1:0] cb_addr_orig,
  input  logic             cb_wr_addr_inc,
  input  logic             cb_wr_en,
  input  logic [7:0]       wr_data,
  input  logic             clr_start,
  output logic             cb_we,
  output logic [CB_AW-1:0] cb_addr,
  output logic [7:0]       cb_din,
  output logic             busy,
  output logic             clr_done,
  output logic             wr_drop,
  output logic [1:0]       fsm_state
);

  // Handshake: cb_wr_en, cw_row_col_update and clr_start are single-cycle
  // strobes with no back-pressure; a write that cannot be held is reported
  // by a one-cycle wr_drop pulse, and cb_we is a one-cycle registered strobe.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam logic [CB_AW-1:0] CLR_LAST = {CB_AW{1'b1}};

  state_t           state, state_n;
  logic [7:0]       row, col, upd_row, upd_col, pend_data;
  logic             pending, upd_pend;
  logic [CB_AW-1:0] row_base, acc, clr_cnt;
  logic [2:0]       mcnt;

  logic [8:0]       xs, ys;
  logic [CB_AW-1:0] xs_a, term, acc_sum;
  logic [31:0]      term_w;
  logic [7:0]       ld_row, ld_col, wr_byte;
  logic [7:0]       row_nx, col_nx;
  logic [CB_AW-1:0] rb_nx;

  logic do_clr, do_load, do_write, hold_wr, drop, load_done, clr_finish;
  logic save_upd, save_cw;

  assign fsm_state = state;
  assign busy      = (state != S_IDLE);

  // Zero-sized window dimensions mean 256.
  assign xs      = (cw_x_size == 8'd0) ? 9'd256 : {1'b0, cw_x_size};
  assign ys      = (cw_y_size == 8'd0) ? 9'd256 : {1'b0, cw_y_size};
  assign xs_a    = CB_AW'(xs);
  assign term_w  = 32'(xs) << mcnt;
  assign term    = term_w[CB_AW-1:0];
  assign acc_sum = acc + (row[mcnt] ? term : '0);

  assign ld_row  = cw_row_col_update ? cw_row : upd_row;
  assign ld_col  = cw_row_col_update ? cw_col : upd_col;
  assign wr_byte = pending ? pend_data : wr_data;

  // Pointer after a write when auto-increment is enabled.
  always_comb begin
    col_nx = col;
    row_nx = row;
    rb_nx  = row_base;
    if (cb_wr_addr_inc) begin
      if ({1'b0, col} >= xs - 9'd1) begin
        col_nx = 8'd0;
        if ({1'b0, row} >= ys - 9'd1) begin
          row_nx = 8'd0;
          rb_nx  = cb_addr_orig;
        end else begin
          row_nx = row + 8'd1;
          rb_nx  = row_base + xs_a;
        end
      end else begin
        col_nx = col + 8'd1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    do_clr     = 1'b0;
    do_load    = 1'b0;
    do_write   = 1'b0;
    hold_wr    = 1'b0;
    drop       = 1'b0;
    load_done  = 1'b0;
    clr_finish = 1'b0;
    save_upd   = 1'b0;
    save_cw    = 1'b0;
    case (state)
      S_IDLE: begin
        if (clr_start) begin
          state_n  = S_CLEAR;
          do_clr   = 1'b1;
          drop     = cb_wr_en;
          save_upd = cw_row_col_update;
          save_cw  = 1'b1;
        end else if (cw_row_col_update || upd_pend) begin
          state_n = S_LOAD;
          do_load = 1'b1;
          drop    = cb_wr_en & pending;
          hold_wr = cb_wr_en & ~pending;
        end else if (cb_wr_en || pending) begin
          do_write = 1'b1;
          hold_wr  = cb_wr_en & pending;
        end
      end
      S_LOAD: begin
        drop    = cb_wr_en & pending;
        hold_wr = cb_wr_en & ~pending;
        if (clr_start) begin
          // Abandoned load is replayed from the latched row/col after the clear.
          state_n  = S_CLEAR;
          do_clr   = 1'b1;
          save_upd = 1'b1;
          save_cw  = cw_row_col_update;
        end else if (cw_row_col_update) begin
          do_load = 1'b1;
        end else if (mcnt == 3'd7) begin
          state_n   = S_IDLE;
          load_done = 1'b1;
        end
      end
      S_CLEAR: begin
        drop     = cb_wr_en;
        save_upd = cw_row_col_update;
        save_cw  = 1'b1;
        if (clr_start) begin
          do_clr = 1'b1;
        end else if (clr_cnt == CLR_LAST) begin
          state_n    = S_IDLE;
          clr_finish = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row       <= 8'd0;
      col       <= 8'd0;
      row_base  <= cb_addr_orig;
      acc       <= '0;
      mcnt      <= 3'd0;
      pending   <= 1'b0;
      pend_data <= 8'd0;
      upd_pend  <= 1'b0;
      upd_row   <= 8'd0;
      upd_col   <= 8'd0;
      clr_cnt   <= '0;
      cb_we     <= 1'b0;
      cb_addr   <= '0;
      cb_din    <= 8'd0;
      clr_done  <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      state   <= state_n;
      cb_we   <= 1'b0;
      wr_drop <= drop;

      if (state == S_CLEAR) begin
        cb_we   <= 1'b1;
        cb_addr <= clr_cnt;
        cb_din  <= CLR_CHAR;
        clr_cnt <= clr_cnt + 1'b1;
      end
      if (do_clr) begin
        clr_cnt  <= '0;
        clr_done <= 1'b0;
      end
      if (clr_finish) clr_done <= 1'b1;

      if (do_load) begin
        row      <= ld_row;
        col      <= ld_col;
        acc      <= cb_addr_orig;
        mcnt     <= 3'd0;
        upd_pend <= 1'b0;
      end else if (state == S_LOAD && !do_clr) begin
        acc  <= acc_sum;
        mcnt <= mcnt + 3'd1;
        if (load_done) row_base <= acc_sum;
      end

      if (save_upd) begin
        upd_pend <= 1'b1;
        upd_row  <= save_cw ? cw_row : row;
        upd_col  <= save_cw ? cw_col : col;
      end

      if (do_write) begin
        cb_we    <= 1'b1;
        cb_addr  <= row_base + CB_AW'(col);
        cb_din   <= wr_byte;
        row      <= row_nx;
        col      <= col_nx;
        row_base <= rb_nx;
        pending  <= 1'b0;
      end
      if (hold_wr) begin
        pending   <= 1'b1;
        pend_data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_disp_cb_wr_ctrl.sv
// Directed bench for disp_cb_wr_ctrl: expected RAM writes are queued as
// stimulus is driven and matched against cb_we cycles by a negedge monitor.
module tb_disp_cb_wr_ctrl;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    cw_row, cw_col, cw_x_size, cw_y_size, wr_data;
  logic          cw_row_col_update, cb_wr_addr_inc, cb_wr_en, clr_start;
  logic [AW-1:0] cb_addr_orig;
  logic          cb_we, busy, clr_done, wr_drop;
  logic [AW-1:0] cb_addr;
  logic [7:0]    cb_din;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;
  logic [AW+7:0] exp_q[$];

  disp_cb_wr_ctrl #(.CB_AW(AW), .CLR_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst),
    .cw_row(cw_row), .cw_col(cw_col), .cw_row_col_update(cw_row_col_update),
    .cw_x_size(cw_x_size), .cw_y_size(cw_y_size), .cb_addr_orig(cb_addr_orig),
    .cb_wr_addr_inc(cb_wr_addr_inc), .cb_wr_en(cb_wr_en), .wr_data(wr_data),
    .clr_start(clr_start), .cb_we(cb_we), .cb_addr(cb_addr), .cb_din(cb_din),
    .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop), .fsm_state(fsm_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] addr, input logic [7:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic drive_wr(input logic [7:0] data);
    wr_data  = data;
    cb_wr_en = 1'b1;
    tick();
    cb_wr_en = 1'b0;
  endtask

  task automatic pulse_update(input logic [7:0] r, input logic [7:0] c);
    cw_row            = r;
    cw_col            = c;
    cw_row_col_update = 1'b1;
    tick();
    cw_row_col_update = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Scoreboard: every cb_we cycle must match the head of the expected queue
  always @(negedge clk) begin
    if (cb_we === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", cb_addr, cb_din);
      end
      if (exp_q.size() != 0) begin
        logic [AW+7:0] e;
        e = exp_q.pop_front();
        check("write_addr", 32'(cb_addr), 32'(e[AW+7:8]));
        check("write_data", 32'(cb_din), 32'(e[7:0]));
      end
    end
  end

  initial begin
    int n, r, c;
    rst = 1'b1;
    cw_row = 8'd0; cw_col = 8'd0; cw_row_col_update = 1'b0;
    cw_x_size = 8'd32; cw_y_size = 8'd8; cb_addr_orig = '0;
    cb_wr_addr_inc = 1'b0; cb_wr_en = 1'b0; wr_data = 8'd0; clr_start = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_cb_we", 32'(cb_we), 32'd0);
    check("rst_cb_addr", 32'(cb_addr), 32'd0);
    check("rst_cb_din", 32'(cb_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clr_done", 32'(clr_done), 32'd0);
    check("rst_wr_drop", 32'(wr_drop), 32'd0);
    rst = 1'b0;
    tick();

    // Plain writes at the reset pointer, no increment
    push_wr(11'd0, 8'h41);
    drive_wr(8'h41);
    check("t1_we_latency", 32'(cb_we), 32'd1);
    tick();
    check("t1_we_one_cycle", 32'(cb_we), 32'd0);
    push_wr(11'd0, 8'h42);
    drive_wr(8'h42);
    tick();

    // Row/col load: 96 + 3*32 + 5
    cb_addr_orig = 11'd96;
    cw_x_size    = 8'd32;
    pulse_update(8'd3, 8'd5);
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    check("t2_busy_cycles", 32'(n), 32'd8);
    push_wr(11'd197, 8'h55);
    drive_wr(8'h55);
    tick();
    tick();

    // Auto-increment over a 4x2 window with wrap to origin
    cb_addr_orig   = 11'd0;
    cw_x_size      = 8'd4;
    cw_y_size      = 8'd2;
    cb_wr_addr_inc = 1'b1;
    pulse_update(8'd0, 8'd0);
    wait_idle();
    r = 0;
    c = 0;
    for (int i = 0; i < 9; i++) begin
      push_wr(AW'(r * 4 + c), 8'(8'h60 + i));
      c++;
      if (c == 4) begin
        c = 0;
        r = (r == 1) ? 0 : r + 1;
      end
      wr_data  = 8'(8'h60 + i);
      cb_wr_en = 1'b1;
      tick();
    end
    cb_wr_en       = 1'b0;
    cb_wr_addr_inc = 1'b0;
    tick();
    tick();
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Writes during LOAD: first held, second dropped
    cw_x_size = 8'd32;
    cw_y_size = 8'd8;
    pulse_update(8'd2, 8'd3);
    push_wr(11'd67, 8'hA1);
    drive_wr(8'hA1);
    check("t4_no_drop_first", 32'(wr_drop), 32'd0);
    drive_wr(8'hB2);
    check("t4_drop_second", 32'(wr_drop), 32'd1);
    tick();
    check("t4_drop_one_cycle", 32'(wr_drop), 32'd0);
    check("t4_still_loading", 32'(busy), 32'd1);
    wait_idle();
    tick();
    tick();
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Full clear, with a discarded write in the middle
    for (int i = 0; i < (1 << AW); i++) push_wr(AW'(i), 8'h20);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_clr_done_low", 32'(clr_done), 32'd0);
    repeat (100) tick();
    drive_wr(8'h99);
    check("t5_drop_in_clear", 32'(wr_drop), 32'd1);
    n = 0;
    while (clr_done !== 1'b1 && n < 3000) begin
      n++;
      tick();
    end
    check("t5_clr_done", 32'(clr_done), 32'd1);
    tick();
    check("t5_we_off", 32'(cb_we), 32'd0);
    check("t5_busy_off", 32'(busy), 32'd0);
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    // Pointer survives the clear
    push_wr(11'd67, 8'h5A);
    drive_wr(8'h5A);
    tick();
    tick();

    // Reset in the middle of a clear
    for (int i = 0; i <= 500; i++) push_wr(AW'(i), 8'h20);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (!(cb_we === 1'b1 && cb_addr === 11'd500) && n < 1000) begin
      n++;
      tick();
    end
    check("t6_reached_500", 32'(cb_addr), 32'd500);
    rst          = 1'b1;
    cb_addr_orig = 11'd300;
    tick();
    check("t6_we_off", 32'(cb_we), 32'd0);
    check("t6_clr_done", 32'(clr_done), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    tick();
    push_wr(11'd300, 8'h77);
    drive_wr(8'h77);
    tick();
    tick();
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
